// File: rtl/operand_issue_pkg.sv
// Shared widths, instruction field positions and issue FSM encoding
// for the operand issue stage.
package operand_issue_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int REG_W  = 3;

  localparam int OPC_W       = 5;
  localparam int OPC_LSB     = 27;
  localparam int RD_LSB      = 24;
  localparam int RS1_LSB     = 21;
  localparam int RS2_LSB     = 18;
  localparam int IMM_SEL_BIT = 17;
  localparam int IMM_W       = 16;
  localparam int IMM_LSB     = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/issue_regfile.sv
// Register file: two async read ports with writeback bypass, one write port.
// Register 0 is hardwired to zero.
module issue_regfile
  import operand_issue_pkg::*;
#(
  parameter int DATA_W = operand_issue_pkg::DATA_W,
  parameter int NREGS  = operand_issue_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // A same-cycle writeback to the source wins over the stored value.
  assign rdata_a = (raddr_a == '0) ? '0 :
                   (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 :
                   (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/operand_issue.sv
// Operand issue stage: scoreboarded acceptance of instructions, operand
// fetch with writeback bypass, and a registered one-cycle ALU issue.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int DATA_W = operand_issue_pkg::DATA_W,
  parameter int NREGS  = operand_issue_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic              wb_valid,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_enable,
  output logic [NREGS-1:0]  busy_mask
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic              imm_sel;
  logic [IMM_W-1:0]  imm;
  logic              unused_instr_bit;

  assign opcode           = instr[OPC_LSB +: OPC_W];
  assign rd               = instr[RD_LSB  +: REG_W];
  assign rs1              = instr[RS1_LSB +: REG_W];
  assign rs2              = instr[RS2_LSB +: REG_W];
  assign imm_sel          = instr[IMM_SEL_BIT];
  assign imm              = instr[IMM_LSB +: IMM_W];
  assign unused_instr_bit = instr[16];

  logic [NREGS-1:0]  wb_clear;
  logic [NREGS-1:0]  busy_eff;
  logic [NREGS-1:0]  busy_next;
  logic              hazard;
  logic              accept;
  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] operand_b;

  always_comb begin
    wb_clear = '0;
    if (wb_valid) begin
      wb_clear[wb_rd] = 1'b1;
    end
  end

  // Hazards are judged after the same-cycle writeback has released its register.
  assign busy_eff = busy_mask & ~wb_clear;
  assign hazard   = busy_eff[rs1] | busy_eff[rs2] | busy_eff[rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    case (state_q)
      ST_RUN: begin
        instr_ready = ~rst & ~hazard;
        if (instr_valid && hazard) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!hazard) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign accept = instr_valid & instr_ready;

  // Set after clear, so an accept and writeback to the same rd leaves it busy.
  always_comb begin
    busy_next = busy_mask & ~wb_clear;
    if (accept) begin
      busy_next[rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_next;
    end
  end

  issue_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs1),
    .rdata_a (rdata_a),
    .raddr_b (rs2),
    .rdata_b (rdata_b),
    .we      (wb_valid),
    .waddr   (wb_rd),
    .wdata   (wb_data)
  );

  assign operand_b = imm_sel ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : rdata_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_enable <= 1'b0;
    end else begin
      alu_enable <= accept;
      if (accept) begin
        alu_opcode <= opcode;
        alu_a      <= rdata_a;
        alu_b      <= operand_b;
      end
    end
  end

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 Parameter DATA_W, default 32: operand and register width.
REQ-002 Parameter NREGS, default 8: register count; register index width is 3.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr_valid  input  1  upstream offers an instruction.
REQ-006 instr_ready  output  1  block accepts an instruction this cycle.
REQ-007 instr  input  32  fields: [31:27] opcode, [26:24] rd, [23:21] rs1, [20:18] rs2, [17] imm_sel, [15:0] imm.
REQ-008 wb_valid  input  1  ALU result is being written back.
REQ-009 wb_rd  input  3  writeback destination register.
REQ-010 wb_data  input  DATA_W  writeback value (the ALU out).
REQ-011 alu_opcode  output  5  opcode presented to the ALU.
REQ-012 alu_a  output  DATA_W  operand A presented to the ALU.
REQ-013 alu_b  output  DATA_W  operand B presented to the ALU.
REQ-014 alu_enable  output  1  one-cycle pulse marking a valid ALU operation.
REQ-015 busy_mask  output  NREGS  scoreboard; bit i set while register i awaits writeback.

Function
REQ-016 An instruction SHALL be accepted only on a rising edge with instr_valid and instr_ready both high.
REQ-017 instr_ready SHALL be high iff the FSM is in RUN and none of rs1, rs2 and rd is busy after the same-cycle writeback clear.
REQ-018 FSM states SHALL be RUN and HOLD: RUN->HOLD when instr_valid is high and a hazard blocks acceptance; HOLD->RUN when the hazard clears; HOLD accepts nothing. In the HOLD->RUN cycle instr_ready stays low, and the instruction is accepted on the next RUN cycle.
REQ-019 Register 0 SHALL read as zero, ignore writes, and never be marked busy.
REQ-020 The operand read for an accepted instruction SHALL return wb_data when wb_valid is high and wb_rd matches the source in that cycle (bypass), and the register file value otherwise.
REQ-021 alu_a SHALL be the rs1 value; alu_b SHALL be the rs2 value when imm_sel=0, or imm sign-extended to DATA_W when imm_sel=1.
REQ-022 Latency: an instruction accepted at edge N SHALL drive alu_opcode, alu_a, alu_b and alu_enable=1 in the cycle after edge N; alu_enable SHALL return low after one cycle unless another instruction is accepted at edge N+1.
REQ-023 alu_opcode, alu_a and alu_b SHALL hold their last values while alu_enable is low.
REQ-024 Acceptance SHALL set busy[rd] (rd!=0), and wb_valid SHALL clear busy[wb_rd] and write wb_data.
REQ-025 When acceptance and writeback target the same rd in one edge, the register SHALL take wb_data and busy SHALL end set.
REQ-026 Writeback to a non-busy register SHALL write the data and leave busy_mask unchanged.
REQ-027 Throughput SHALL be one instruction per cycle when no hazards are present.

Reset
REQ-028 While rst is high, every register file entry SHALL be 0, busy_mask SHALL be 0, and alu_opcode, alu_a, alu_b and alu_enable SHALL all be 0.
REQ-029 During reset the FSM SHALL be in RUN, and instr_ready SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight issue, and no alu_enable pulse SHALL occur after the reset assertion.

Structure
REQ-031 A shared package SHALL hold DATA_W, NREGS, the instruction field bit positions and the RUN/HOLD state encoding.
REQ-032 The register file SHALL be a sub-module named issue_regfile, with two read ports, one write port and asynchronous reset.

Verification
REQ-033 The bench SHALL cover: reset, then writeback r1=0x0F0F0F0F and r2=0xFFFFFFFF, then issue opcode 01000 rd=3 rs1=1 rs2=2 -> next cycle alu_enable=1, alu_a=0x0F0F0F0F, alu_b=0xFFFFFFFF, busy_mask=0x08.
REQ-034 The bench SHALL cover: imm_sel=1, imm=0x8000, rs1=0 -> alu_a=0, alu_b=0xFFFF8000.
REQ-035 The bench SHALL cover: issue rd=3, then an instruction with rs1=3 -> instr_ready=0 and state HOLD until writeback r3=0x12345678; the instruction is accepted on the next RUN cycle and alu_a=0x12345678.
REQ-036 The bench SHALL cover: writeback r4=0xA5A5A5A5 in the same cycle an instruction with rs2=4 is accepted -> alu_b=0xA5A5A5A5 via bypass.
REQ-037 The bench SHALL cover: back-to-back independent instructions over 4 cycles -> alu_enable high for 4 consecutive cycles.
REQ-038 The bench SHALL cover: rst asserted with busy_mask=0x0E and alu_enable=1 -> all outputs 0 immediately, with no later alu_enable pulse.
